spi_shift_engine: RTL and testbench

SPI master serial engine that sits directly downstream of the SPI APB register block. It consumes the control fields (enable, clock polarity and phase, bit order, baud prescaler and divider) and the data-register write strobe. It generates SCK, MOSI and SS_n, samples MISO, and returns received data and status flags (SPTEF, SPIF, overrun) to the register block. The engine operates in 8-bit master mode only.

---
 rtl/spi_pkg.sv | 44 ++++
 rtl/spi_baud_gen.sv | 40 ++++
 rtl/spi_shift_engine.sv | 174 +++++++++++++++++
 tb/tb_spi_shift_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master serial engine:
//   - one-hot FSM state encoding
//   - data width and baud counter width
//   - helpers for half-period calculation and bit-order aware shifting
// ----------------------------------------------------------------------------
package spi_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int BAUD_W     = 11;   // holds H up to 8 << 7 = 1024

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_LEAD  = 5'b00010,
      ST_SHIFT = 5'b00100,
      ST_TRAIL = 5'b01000,
      ST_GAP   = 5'b10000
   } spi_state_e;

   // Half SCK period in clocks: (sppr + 1) << spr
   function automatic logic [BAUD_W-1:0] half_period(input logic [2:0] sppr,
                                                     input logic [2:0] spr);
      return (BAUD_W'(sppr) + BAUD_W'(1)) << spr;
   endfunction

   // Next bit to leave the shifter
   function automatic logic out_bit(input logic [DATA_WIDTH-1:0] d, input logic lsbfe);
      return lsbfe ? d[0] : d[DATA_WIDTH-1];
   endfunction

   // Drop the bit just driven
   function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] d,
                                                       input logic lsbfe);
      return lsbfe ? (d >> 1) : (d << 1);
   endfunction

   // Insert a received bit so the first bit ends up in its proper position
   function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] d,
                                                      input logic b, input logic lsbfe);
      return lsbfe ? {b, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], b};
   endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// ----------------------------------------------------------------------------
// spi_baud_gen
// Half-period tick generator. A load captures H and restarts the count; while
// enabled, tick_out pulses for one clock every H clocks, the first one H
// clocks after the load.
//   apb_clk_in, apb_rstn_in : clock, async active-low reset
//   en_in                   : count enable
//   load_in                 : capture half_in and restart
//   half_in                 : half period in clocks (1..1024)
//   tick_out                : one-cycle pulse every H clocks
// ----------------------------------------------------------------------------
module spi_baud_gen
   import spi_pkg::*;
(
   input  logic              apb_clk_in,
   input  logic              apb_rstn_in,
   input  logic              en_in,
   input  logic              load_in,
   input  logic [BAUD_W-1:0] half_in,
   output logic              tick_out
);

   logic [BAUD_W-1:0] half_q;
   logic [BAUD_W-1:0] cnt_q;

   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         half_q <= BAUD_W'(1);
         cnt_q  <= '0;
      end else if (load_in) begin
         half_q <= half_in;
         cnt_q  <= half_in - BAUD_W'(1);
      end else if (en_in) begin
         cnt_q  <= (cnt_q == '0) ? half_q - BAUD_W'(1) : cnt_q - BAUD_W'(1);
      end
   end

   assign tick_out = en_in && !load_in && (cnt_q == '0);

endmodule

// File: rtl/spi_shift_engine.sv
// ----------------------------------------------------------------------------
// spi_shift_engine
// 8-bit SPI master serial engine behind the SPI register block.
//   apb_clk_in, apb_rstn_in : clock, async active-low reset
//   spe_in                  : enable; low aborts any transfer
//   cpol_in/cpha_in/lsbfe_in: SCK idle level, sample phase, bit order
//   sppr_in/spr_in          : baud prescaler / divider
//   tx_data_in, tx_load_in  : data register write into the 1-byte buffer
//   rx_clear_in             : clears SPIF and overrun
//   tx_empty_out (SPTEF), rx_data_out, rx_full_out (SPIF), overrun_out, busy_out
//   sck_out, mosi_out, miso_in, ss_n_out : SPI pins
// ----------------------------------------------------------------------------
module spi_shift_engine #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  apb_clk_in,
   input  logic                  apb_rstn_in,
   input  logic                  spe_in,
   input  logic                  cpol_in,
   input  logic                  cpha_in,
   input  logic                  lsbfe_in,
   input  logic [2:0]            sppr_in,
   input  logic [2:0]            spr_in,
   input  logic [DATA_WIDTH-1:0] tx_data_in,
   input  logic                  tx_load_in,
   input  logic                  rx_clear_in,
   output logic                  tx_empty_out,
   output logic [DATA_WIDTH-1:0] rx_data_out,
   output logic                  rx_full_out,
   output logic                  overrun_out,
   output logic                  busy_out,
   output logic                  sck_out,
   output logic                  mosi_out,
   input  logic                  miso_in,
   output logic                  ss_n_out
);

   import spi_pkg::*;

   spi_state_e            state_q, state_d;
   logic                  tx_full_q;
   logic [DATA_WIDTH-1:0] tx_buf_q, tx_sr_q, rx_sr_q, rx_data_q;
   logic [3:0]            edge_cnt_q;     // SCK edges done in SHIFT, 0..15
   logic                  cpha_q, lsbfe_q;
   logic                  sck_q, mosi_q, ss_n_q, rx_full_q, ovr_q;
   logic                  tick, start, edge_ev, sample_ev, drive_ev, complete, abort_ev;

   spi_baud_gen u_baud (
      .apb_clk_in  (apb_clk_in),
      .apb_rstn_in (apb_rstn_in),
      .en_in       (state_q != ST_IDLE),
      .load_in     (start),
      .half_in     (half_period(sppr_in, spr_in)),
      .tick_out    (tick)
   );

   // ---- FSM: state register ----
   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) state_q <= ST_IDLE;
      else              state_q <= state_d;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (spe_in && tx_full_q)             state_d = ST_LEAD;
         ST_LEAD:  if (tick)                            state_d = ST_SHIFT;
         ST_SHIFT: if (tick && edge_cnt_q == 4'd15)     state_d = ST_TRAIL;
         ST_TRAIL: if (tick)                            state_d = ST_GAP;
         ST_GAP:   if (tick)                            state_d = ST_IDLE;
         default:                                       state_d = ST_IDLE;
      endcase
      if (!spe_in) state_d = ST_IDLE;
   end

   // ---- FSM: outputs / datapath strobes ----
   // edge_cnt_q[0]==0 marks an odd edge (1,3,..). cpha=0 samples odd edges,
   // cpha=1 samples even edges; the other edges drive. Edge 16 never drives
   // (it would push a ninth bit).
   always_comb begin
      start     = (state_q == ST_IDLE) && spe_in && tx_full_q;
      edge_ev   = (state_q == ST_SHIFT) && tick && spe_in;
      sample_ev = edge_ev && (edge_cnt_q[0] == cpha_q);
      drive_ev  = edge_ev && (edge_cnt_q[0] != cpha_q) && (edge_cnt_q != 4'd15);
      complete  = (state_q == ST_TRAIL) && tick && spe_in;
      abort_ev  = (state_q != ST_IDLE) && !spe_in;
      busy_out  = (state_q != ST_IDLE);
   end

   // ---- transmit buffer ----
   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         tx_full_q <= 1'b0;
         tx_buf_q  <= '0;
      end else if (abort_ev || start) begin
         tx_full_q <= 1'b0;
      end else if (tx_load_in && spe_in && !tx_full_q) begin
         tx_full_q <= 1'b1;
         tx_buf_q  <= tx_data_in;
      end
   end

   // ---- shifters ----
   // With cpha=0 the first bit goes out as LEAD is entered, so the
   // shifter is loaded with that bit already consumed.
   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         cpha_q     <= 1'b0;
         lsbfe_q    <= 1'b0;
         edge_cnt_q <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         mosi_q     <= 1'b0;
      end else if (start) begin
         cpha_q     <= cpha_in;
         lsbfe_q    <= lsbfe_in;
         edge_cnt_q <= '0;
         rx_sr_q    <= '0;
         tx_sr_q    <= cpha_in ? tx_buf_q : shift_out(tx_buf_q, lsbfe_in);
         if (!cpha_in) mosi_q <= out_bit(tx_buf_q, lsbfe_in);
      end else begin
         if (edge_ev)   edge_cnt_q <= edge_cnt_q + 4'd1;
         if (sample_ev) rx_sr_q    <= shift_in(rx_sr_q, miso_in, lsbfe_q);
         if (drive_ev) begin
            mosi_q  <= out_bit(tx_sr_q, lsbfe_q);
            tx_sr_q <= shift_out(tx_sr_q, lsbfe_q);
         end
      end
   end

   // ---- pins ----
   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         sck_q  <= 1'b0;
         ss_n_q <= 1'b1;
      end else begin
         if (state_q == ST_IDLE || abort_ev) sck_q <= cpol_in;
         else if (edge_ev)                   sck_q <= ~sck_q;
         ss_n_q <= !(state_d == ST_LEAD || state_d == ST_SHIFT || state_d == ST_TRAIL);
      end
   end

   // ---- receive status; a completion outranks a same-cycle clear ----
   always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
      if (!apb_rstn_in) begin
         rx_full_q <= 1'b0;
         ovr_q     <= 1'b0;
         rx_data_q <= '0;
      end else begin
         if (rx_clear_in) begin
            rx_full_q <= 1'b0;
            ovr_q     <= 1'b0;
         end
         if (complete) begin
            if (rx_full_q && !rx_clear_in) begin
               ovr_q <= 1'b1;
            end else begin
               rx_data_q <= rx_sr_q;
               rx_full_q <= 1'b1;
            end
         end
      end
   end

   assign tx_empty_out = !tx_full_q;
   assign rx_data_out  = rx_data_q;
   assign rx_full_out  = rx_full_q;
   assign overrun_out  = ovr_q;
   assign sck_out      = sck_q;
   assign mosi_out     = mosi_q;
   assign ss_n_out     = ss_n_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// ----------------------------------------------------------------------------
// tb_spi_shift_engine
// Directed bench for spi_shift_engine with hand-computed expectations.
// ----------------------------------------------------------------------------
module tb_spi_shift_engine;

   logic       clk, rst_n;
   logic       spe, cpol, cpha, lsbfe;
   logic [2:0] sppr, spr;
   logic [7:0] tx_data;
   logic       tx_load, rx_clear;
   logic       tx_empty, rx_full, ovr, busy, sck, mosi, miso, ss_n;
   logic [7:0] rx_data;
   logic       loopback, tie_val;

   int         n_cmp = 0;
   int         n_err = 0;

   logic [7:0] bits;
   int         lo, per;
   bit         to, ok;
   int         e;
   logic       p;

   assign miso = loopback ? mosi : tie_val;

   spi_shift_engine #(.DATA_WIDTH(8)) dut (
      .apb_clk_in   (clk),
      .apb_rstn_in  (rst_n),
      .spe_in       (spe),
      .cpol_in      (cpol),
      .cpha_in      (cpha),
      .lsbfe_in     (lsbfe),
      .sppr_in      (sppr),
      .spr_in       (spr),
      .tx_data_in   (tx_data),
      .tx_load_in   (tx_load),
      .rx_clear_in  (rx_clear),
      .tx_empty_out (tx_empty),
      .rx_data_out  (rx_data),
      .rx_full_out  (rx_full),
      .overrun_out  (ovr),
      .busy_out     (busy),
      .sck_out      (sck),
      .mosi_out     (mosi),
      .miso_in      (miso),
      .ss_n_out     (ss_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] d);
      @(negedge clk);
      tx_data = d;
      tx_load = 1'b1;
      @(negedge clk);
      tx_load = 1'b0;
   endtask

   task automatic clear_rx();
      @(negedge clk);
      rx_clear = 1'b1;
      @(negedge clk);
      rx_clear = 1'b0;
   endtask

   // Follows one SS frame: collects MOSI at the sampling edges (first bit ends
   // in bit 7), counts SS-low cycles and measures edge1->edge3 distance.
   task automatic watch(input bit ph, output logic [7:0] b, output int low,
                        output int period, output bit tmo);
      int   edges = 0, t1 = 0, t3 = 0, cyc = 0;
      bit   seen = 0;
      logic prev;
      b = 8'h00; low = 0; tmo = 0;
      @(negedge clk);
      prev = sck;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (cyc > 20000) begin tmo = 1; break; end
         if (sck !== prev) begin
            edges++;
            if (edges == 1) t1 = cyc;
            if (edges == 3) t3 = cyc;
            if ((edges % 2 == 1) != ph) b = {b[6:0], mosi};
         end
         prev = sck;
         if (ss_n === 1'b0) begin
            seen = 1;
            low++;
         end else if (seen) break;
      end
      period = t3 - t1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_tx_empty"}, 32'(tx_empty), 32'h1);
      chk({tag, "_rx_full"},  32'(rx_full),  32'h0);
      chk({tag, "_ovr"},      32'(ovr),      32'h0);
      chk({tag, "_rx_data"},  32'(rx_data),  32'h0);
      chk({tag, "_busy"},     32'(busy),     32'h0);
      chk({tag, "_sck"},      32'(sck),      32'h0);
      chk({tag, "_mosi"},     32'(mosi),     32'h0);
      chk({tag, "_ss_n"},     32'(ss_n),     32'h1);
   endtask

   initial begin
      rst_n = 1'b0; spe = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
      sppr = 3'd0; spr = 3'd0; tx_data = 8'h00; tx_load = 1'b0; rx_clear = 1'b0;
      loopback = 1'b1; tie_val = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ---- mode 0, H=1, MSB first, 0xA5 loopback; start timing ----
      fork
         watch(1'b0, bits, lo, per, to);
         begin
            load(8'hA5);
            chk("t1_c1_tx_empty", 32'(tx_empty), 32'h0);
            chk("t1_c1_ss_n",     32'(ss_n),     32'h1);
            @(negedge clk);
            chk("t1_c2_ss_n",     32'(ss_n),     32'h0);
            chk("t1_c2_busy",     32'(busy),     32'h1);
            chk("t1_c2_tx_empty", 32'(tx_empty), 32'h1);
         end
      join
      chk("t1_timeout", 32'(to),      32'h0);
      chk("t1_mosi",    32'(bits),    32'hA5);
      chk("t1_ss_low",  32'(lo),      32'd18);
      chk("t1_period",  32'(per),     32'd2);
      chk("t1_spif",    32'(rx_full), 32'h1);
      chk("t1_rx",      32'(rx_data), 32'hA5);
      clear_rx();

      // ---- mode 3, LSB first, H=6, 0x3C, MISO tied 1 ----
      cpol = 1'b1; cpha = 1'b1; lsbfe = 1'b1; sppr = 3'd2; spr = 3'd1;
      loopback = 1'b0; tie_val = 1'b1;
      repeat (2) @(negedge clk);
      chk("t2_sck_idle", 32'(sck), 32'h1);
      fork
         watch(1'b1, bits, lo, per, to);
         load(8'h3C);
      join
      chk("t2_timeout", 32'(to),      32'h0);
      chk("t2_mosi",    32'(bits),    32'h3C);
      chk("t2_ss_low",  32'(lo),      32'd108);
      chk("t2_period",  32'(per),     32'd12);
      chk("t2_rx",      32'(rx_data), 32'hFF);
      chk("t2_spif",    32'(rx_full), 32'h1);

      // ---- second byte without clear: overrun ----
      cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0; sppr = 3'd0; spr = 3'd0;
      loopback = 1'b1;
      repeat (3) @(negedge clk);
      fork
         watch(1'b0, bits, lo, per, to);
         load(8'h12);
      join
      chk("t3_timeout", 32'(to),      32'h0);
      chk("t3_rx_hold", 32'(rx_data), 32'hFF);
      chk("t3_ovr",     32'(ovr),     32'h1);
      chk("t3_spif",    32'(rx_full), 32'h1);
      clear_rx();
      chk("t3_clr_spif", 32'(rx_full), 32'h0);
      chk("t3_clr_ovr",  32'(ovr),     32'h0);

      // ---- mode 1, LSB first, 0x01 loopback: bit0 leaves first ----
      cpha = 1'b1; lsbfe = 1'b1;
      repeat (2) @(negedge clk);
      fork
         watch(1'b1, bits, lo, per, to);
         load(8'h01);
      join
      chk("t3b_timeout", 32'(to),      32'h0);
      chk("t3b_mosi",    32'(bits),    32'h80);
      chk("t3b_rx",      32'(rx_data), 32'h01);
      clear_rx();
      cpha = 1'b0; lsbfe = 1'b0;
      repeat (2) @(negedge clk);

      // ---- buffer write while full is dropped ----
      fork
         watch(1'b0, bits, lo, per, to);
         begin
            load(8'h11);
            repeat (4) @(negedge clk);
            load(8'h22);
            chk("t4_buf_full", 32'(tx_empty), 32'h0);
            load(8'h33);
         end
      join
      chk("t4_b1_to",   32'(to),   32'h0);
      chk("t4_b1_mosi", 32'(bits), 32'h11);
      watch(1'b0, bits, lo, per, to);
      chk("t4_b2_to",   32'(to),   32'h0);
      chk("t4_b2_mosi", 32'(bits), 32'h22);
      chk("t4_b2_low",  32'(lo),   32'd18);
      e = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ss_n !== 1'b1) e++;
      end
      chk("t4_no_third", 32'(e),        32'd0);
      chk("t4_tx_empty", 32'(tx_empty), 32'h1);
      chk("t4_rx",       32'(rx_data),  32'h11);
      chk("t4_ovr",      32'(ovr),      32'h1);
      clear_rx();

      // ---- abort at edge 7, H=2 ----
      sppr = 3'd1;
      load(8'h5A);
      e = 0; ok = 0; p = sck;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (sck !== p) e++;
         p = sck;
         if (e == 7) begin ok = 1; break; end
      end
      chk("t5_reach", 32'(ok), 32'h1);
      spe = 1'b0;
      @(negedge clk);
      chk("t5_ss_n",     32'(ss_n),     32'h1);
      chk("t5_tx_empty", 32'(tx_empty), 32'h1);
      chk("t5_busy",     32'(busy),     32'h0);
      chk("t5_sck",      32'(sck),      32'h0);
      load(8'h77);
      chk("t5_load_off", 32'(tx_empty), 32'h1);
      repeat (20) @(negedge clk);
      chk("t5_spif",     32'(rx_full),  32'h0);
      chk("t5_rx_hold",  32'(rx_data),  32'h11);
      spe = 1'b1;
      repeat (2) @(negedge clk);

      // ---- async reset mid-SHIFT, H=4, then normal byte ----
      sppr = 3'd3;
      load(8'hC3);
      e = 0; ok = 0; p = sck;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         if (sck !== p) e++;
         p = sck;
         if (e == 5) begin ok = 1; break; end
      end
      chk("t6_reach", 32'(ok), 32'h1);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("t6_async");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      fork
         watch(1'b0, bits, lo, per, to);
         load(8'hC3);
      join
      chk("t6_timeout", 32'(to),      32'h0);
      chk("t6_mosi",    32'(bits),    32'hC3);
      chk("t6_ss_low",  32'(lo),      32'd72);
      chk("t6_rx",      32'(rx_data), 32'hC3);
      chk("t6_spif",    32'(rx_full), 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
